// File: rtl/hazard_forward_unit.sv
// ---------------------------------------------------------------------------
// hazard_forward_unit
//
// Hazard controller for the 5-stage MIPS pipeline. It keeps shadow copies of
// the destination information held in the ID/EX, EX/MEM and MEM/WB latches.
// From those copies it produces the operand-forwarding selects for Execute,
// detects load-use hazards (stalling PC and IF/ID and injecting a bubble),
// and applies the taken-branch flush. Saturating counters record stall and
// flush cycles for performance debug.
//
// Parameters
//   REG_AW       register-address width
//   CNT_W        width of the stall/flush event counters
//
// Ports
//   clk           pipeline clock, rising edge
//   reset         asynchronous, active-high; clears all shadow state/counters
//   if_id_rs      rs field of the instruction in decode
//   if_id_rt      rt field of the instruction in decode
//   dec_rs_used   decoded instruction reads rs
//   dec_rt_used   decoded instruction reads rt
//   dec_dest      decoded destination register (rd or rt, already selected)
//   dec_reg_write decoded instruction writes a register
//   dec_mem_read  decoded instruction is a load
//   branch_taken  taken branch/jump resolved in EX this cycle
//   forward_a     A-operand select: 00 regfile, 01 MEM/WB, 10 EX/MEM
//   forward_b     B-operand select, same encoding
//   pc_write      PC update enable
//   if_id_write   IF/ID latch enable
//   if_id_flush   zero the IF/ID latch at the next edge
//   id_ex_bubble  load a NOP into ID/EX at the next edge
//   stall_count   saturating count of load-use stall cycles
//   flush_count   saturating count of branch-flush cycles
// ---------------------------------------------------------------------------
module hazard_forward_unit #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] if_id_rs,
  input  logic [REG_AW-1:0] if_id_rt,
  input  logic              dec_rs_used,
  input  logic              dec_rt_used,
  input  logic [REG_AW-1:0] dec_dest,
  input  logic              dec_reg_write,
  input  logic              dec_mem_read,
  input  logic              branch_taken,
  output logic [1:0]        forward_a,
  output logic [1:0]        forward_b,
  output logic              pc_write,
  output logic              if_id_write,
  output logic              if_id_flush,
  output logic              id_ex_bubble,
  output logic [CNT_W-1:0]  stall_count,
  output logic [CNT_W-1:0]  flush_count
);

  // EX slot shadow
  logic [REG_AW-1:0] ex_rs;
  logic [REG_AW-1:0] ex_rt;
  logic              ex_rs_used;
  logic              ex_rt_used;
  logic [REG_AW-1:0] ex_dest;
  logic              ex_reg_write;
  logic              ex_mem_read;

  // MEM and WB slot shadows
  logic [REG_AW-1:0] mem_dest;
  logic              mem_reg_write;
  logic [REG_AW-1:0] wb_dest;
  logic              wb_reg_write;

  logic load_use;
  logic stall_event;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Shadow pipeline: the EX slot takes the decoded instruction unless a
  // bubble is being inserted, in which case every enable is cleared. MEM and
  // WB simply follow one and two cycles behind.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_rs         <= '0;
      ex_rt         <= '0;
      ex_rs_used    <= 1'b0;
      ex_rt_used    <= 1'b0;
      ex_dest       <= '0;
      ex_reg_write  <= 1'b0;
      ex_mem_read   <= 1'b0;
      mem_dest      <= '0;
      mem_reg_write <= 1'b0;
      wb_dest       <= '0;
      wb_reg_write  <= 1'b0;
    end else begin
      if (id_ex_bubble) begin
        ex_rs        <= '0;
        ex_rt        <= '0;
        ex_rs_used   <= 1'b0;
        ex_rt_used   <= 1'b0;
        ex_dest      <= '0;
        ex_reg_write <= 1'b0;
        ex_mem_read  <= 1'b0;
      end else begin
        ex_rs        <= if_id_rs;
        ex_rt        <= if_id_rt;
        ex_rs_used   <= dec_rs_used;
        ex_rt_used   <= dec_rt_used;
        ex_dest      <= dec_dest;
        ex_reg_write <= dec_reg_write;
        ex_mem_read  <= dec_mem_read;
      end
      mem_dest      <= ex_dest;
      mem_reg_write <= ex_reg_write;
      wb_dest       <= mem_dest;
      wb_reg_write  <= mem_reg_write;
    end
  end

  // Operand forwarding. The EX/MEM producer is checked first so the youngest
  // writer of a register wins over an older one sitting in MEM/WB. Register 0
  // is hard-wired to zero and therefore never forwarded.
  always_comb begin
    forward_a = 2'b00;
    forward_b = 2'b00;
    if (ex_rs_used && mem_reg_write && (mem_dest != '0) && (mem_dest == ex_rs))
      forward_a = 2'b10;
    else if (ex_rs_used && wb_reg_write && (wb_dest != '0) && (wb_dest == ex_rs))
      forward_a = 2'b01;
    if (ex_rt_used && mem_reg_write && (mem_dest != '0) && (mem_dest == ex_rt))
      forward_b = 2'b10;
    else if (ex_rt_used && wb_reg_write && (wb_dest != '0) && (wb_dest == ex_rt))
      forward_b = 2'b01;
  end

  // A load in EX whose destination is read by the instruction in decode
  // cannot be satisfied by forwarding, so decode must wait one cycle.
  assign load_use = ex_mem_read && (ex_dest != '0) &&
                    ((dec_rs_used && (ex_dest == if_id_rs)) ||
                     (dec_rt_used && (ex_dest == if_id_rt)));

  // A taken branch discards the instruction in decode anyway, so it overrides
  // any stall that instruction would otherwise have caused.
  assign stall_event = load_use && !branch_taken;

  // Pipeline control. Flush keeps the front end moving (fetching the branch
  // target) while squashing IF/ID and ID/EX; a stall freezes the front end
  // and feeds a bubble into EX.
  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    if (branch_taken) begin
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
    end else if (load_use) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
    end
  end

  // Saturating event counters for performance debug; once all-ones they
  // stick there instead of wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (stall_event && (stall_count != CNT_MAX))
        stall_count <= stall_count + CNT_ONE;
      if (branch_taken && (flush_count != CNT_MAX))
        flush_count <= flush_count + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// ---------------------------------------------------------------------------
// tb_hazard_forward_unit
//
// Directed bench for hazard_forward_unit. Instruction sequences are pushed
// through the decode inputs one per clock and the forwarding/control outputs
// are compared with hand-derived values. A second instance with 4-bit
// counters shares the same stimulus to exercise counter saturation.
// ---------------------------------------------------------------------------
module tb_hazard_forward_unit;

  logic       clk;
  logic       reset;
  logic [4:0] if_id_rs;
  logic [4:0] if_id_rt;
  logic       dec_rs_used;
  logic       dec_rt_used;
  logic [4:0] dec_dest;
  logic       dec_reg_write;
  logic       dec_mem_read;
  logic       branch_taken;

  logic [1:0]  forward_a;
  logic [1:0]  forward_b;
  logic        pc_write;
  logic        if_id_write;
  logic        if_id_flush;
  logic        id_ex_bubble;
  logic [15:0] stall_count;
  logic [15:0] flush_count;

  logic [1:0] sat_forward_a;
  logic [1:0] sat_forward_b;
  logic       sat_pc_write;
  logic       sat_if_id_write;
  logic       sat_if_id_flush;
  logic       sat_id_ex_bubble;
  logic [3:0] sat_stall_count;
  logic [3:0] sat_flush_count;

  int checks;
  int errors;

  hazard_forward_unit #(.REG_AW(5), .CNT_W(16)) dut (
    .clk           (clk),
    .reset         (reset),
    .if_id_rs      (if_id_rs),
    .if_id_rt      (if_id_rt),
    .dec_rs_used   (dec_rs_used),
    .dec_rt_used   (dec_rt_used),
    .dec_dest      (dec_dest),
    .dec_reg_write (dec_reg_write),
    .dec_mem_read  (dec_mem_read),
    .branch_taken  (branch_taken),
    .forward_a     (forward_a),
    .forward_b     (forward_b),
    .pc_write      (pc_write),
    .if_id_write   (if_id_write),
    .if_id_flush   (if_id_flush),
    .id_ex_bubble  (id_ex_bubble),
    .stall_count   (stall_count),
    .flush_count   (flush_count)
  );

  hazard_forward_unit #(.REG_AW(5), .CNT_W(4)) dut_sat (
    .clk           (clk),
    .reset         (reset),
    .if_id_rs      (if_id_rs),
    .if_id_rt      (if_id_rt),
    .dec_rs_used   (dec_rs_used),
    .dec_rt_used   (dec_rt_used),
    .dec_dest      (dec_dest),
    .dec_reg_write (dec_reg_write),
    .dec_mem_read  (dec_mem_read),
    .branch_taken  (branch_taken),
    .forward_a     (sat_forward_a),
    .forward_b     (sat_forward_b),
    .pc_write      (sat_pc_write),
    .if_id_write   (sat_if_id_write),
    .if_id_flush   (sat_if_id_flush),
    .id_ex_bubble  (sat_id_ex_bubble),
    .stall_count   (sat_stall_count),
    .flush_count   (sat_flush_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one decoded instruction on the decode inputs.
  task automatic apply_stimulus(input logic [4:0] rs, input logic [4:0] rt,
                                input logic rs_used, input logic rt_used,
                                input logic [4:0] dest, input logic reg_write,
                                input logic mem_read);
    if_id_rs      = rs;
    if_id_rt      = rt;
    dec_rs_used   = rs_used;
    dec_rt_used   = rt_used;
    dec_dest      = dest;
    dec_reg_write = reg_write;
    dec_mem_read  = mem_read;
  endtask

  // Advance one pipeline edge; inputs change and outputs are sampled 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    apply_stimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    repeat (3) tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    branch_taken = 1'b0;
    apply_stimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    #2;
    checks++;
    if (forward_a !== 2'b00 || forward_b !== 2'b00) begin
      errors++;
      $display("[TB] FAIL reset_fwd: got %b/%b expected 00/00", forward_a, forward_b);
    end
    checks++;
    if ({pc_write, if_id_write, if_id_flush, id_ex_bubble} !== 4'b1100) begin
      errors++;
      $display("[TB] FAIL reset_ctrl: got %b expected 1100",
               {pc_write, if_id_write, if_id_flush, id_ex_bubble});
    end
    checks++;
    if (stall_count !== 16'd0 || flush_count !== 16'd0) begin
      errors++;
      $display("[TB] FAIL reset_cnt: got %0d/%0d expected 0/0", stall_count, flush_count);
    end
    @(negedge clk);
    reset = 1'b0;
    tick();
  endtask

  // add $3,$1,$2 ; sub $4,$3,$5
  task automatic test_ex_mem_forward();
    apply_stimulus(5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0);
    tick();
    apply_stimulus(5'd3, 5'd5, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0);
    tick();
    checks++;
    if (forward_a !== 2'b10) begin
      errors++;
      $display("[TB] FAIL ex_mem_fwd_a: got %b expected 10", forward_a);
    end
    checks++;
    if (forward_b !== 2'b00) begin
      errors++;
      $display("[TB] FAIL ex_mem_fwd_b: got %b expected 00", forward_b);
    end
    drain();
  endtask

  // add $3,$1,$2 ; add $8,$9,$10 ; or $6,$7,$3
  task automatic test_mem_wb_forward();
    apply_stimulus(5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0);
    tick();
    apply_stimulus(5'd9, 5'd10, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0);
    tick();
    apply_stimulus(5'd7, 5'd3, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);
    tick();
    checks++;
    if (forward_b !== 2'b01) begin
      errors++;
      $display("[TB] FAIL mem_wb_fwd_b: got %b expected 01", forward_b);
    end
    checks++;
    if (forward_a !== 2'b00) begin
      errors++;
      $display("[TB] FAIL mem_wb_fwd_a: got %b expected 00", forward_a);
    end
    drain();
  endtask

  // add $3,$1,$2 ; add $3,$3,$1 ; sub $4,$3,$3
  task automatic test_priority();
    apply_stimulus(5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0);
    tick();
    apply_stimulus(5'd3, 5'd1, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0);
    tick();
    checks++;
    if (forward_a !== 2'b10 || forward_b !== 2'b00) begin
      errors++;
      $display("[TB] FAIL prio_second_writer: got %b/%b expected 10/00", forward_a, forward_b);
    end
    apply_stimulus(5'd3, 5'd3, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0);
    tick();
    checks++;
    if (forward_a !== 2'b10 || forward_b !== 2'b10) begin
      errors++;
      $display("[TB] FAIL prio_youngest: got %b/%b expected 10/10", forward_a, forward_b);
    end
    drain();
  endtask

  // lw $2,0($1) ; add $4,$2,$2
  task automatic test_load_use();
    apply_stimulus(5'd1, 5'd0, 1'b1, 1'b0, 5'd2, 1'b1, 1'b1);
    tick();
    apply_stimulus(5'd2, 5'd2, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0);
    #1;
    checks++;
    if ({pc_write, if_id_write, if_id_flush, id_ex_bubble} !== 4'b0001) begin
      errors++;
      $display("[TB] FAIL lu_stall: got %b expected 0001",
               {pc_write, if_id_write, if_id_flush, id_ex_bubble});
    end
    tick();
    checks++;
    if (stall_count !== 16'd1) begin
      errors++;
      $display("[TB] FAIL lu_stall_count: got %0d expected 1", stall_count);
    end
    checks++;
    if ({pc_write, if_id_write, id_ex_bubble} !== 3'b110) begin
      errors++;
      $display("[TB] FAIL lu_single_stall: got %b expected 110",
               {pc_write, if_id_write, id_ex_bubble});
    end
    tick();
    checks++;
    if (forward_a !== 2'b01 || forward_b !== 2'b01) begin
      errors++;
      $display("[TB] FAIL lu_fwd: got %b/%b expected 01/01", forward_a, forward_b);
    end
    drain();
  endtask

  // addi $0,$0,5 ; add $1,$0,$0 ; lw $0 ; use of $0
  task automatic test_reg_zero();
    apply_stimulus(5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0);
    tick();
    apply_stimulus(5'd0, 5'd0, 1'b1, 1'b1, 5'd1, 1'b1, 1'b0);
    tick();
    checks++;
    if (forward_a !== 2'b00 || forward_b !== 2'b00) begin
      errors++;
      $display("[TB] FAIL zero_fwd: got %b/%b expected 00/00", forward_a, forward_b);
    end
    drain();
    apply_stimulus(5'd1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1);
    tick();
    apply_stimulus(5'd0, 5'd0, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0);
    #1;
    checks++;
    if ({pc_write, if_id_write, id_ex_bubble} !== 3'b110) begin
      errors++;
      $display("[TB] FAIL zero_no_stall: got %b expected 110",
               {pc_write, if_id_write, id_ex_bubble});
    end
    tick();
    checks++;
    if (stall_count !== 16'd1) begin
      errors++;
      $display("[TB] FAIL zero_stall_count: got %0d expected 1", stall_count);
    end
    drain();
  endtask

  // Taken branch in the same cycle as a load-use match.
  task automatic test_flush_vs_stall();
    apply_stimulus(5'd1, 5'd0, 1'b1, 1'b0, 5'd2, 1'b1, 1'b1);
    tick();
    apply_stimulus(5'd2, 5'd2, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0);
    branch_taken = 1'b1;
    #1;
    checks++;
    if ({pc_write, if_id_write, if_id_flush, id_ex_bubble} !== 4'b1111) begin
      errors++;
      $display("[TB] FAIL flush_ctrl: got %b expected 1111",
               {pc_write, if_id_write, if_id_flush, id_ex_bubble});
    end
    tick();
    branch_taken = 1'b0;
    #1;
    checks++;
    if (flush_count !== 16'd1) begin
      errors++;
      $display("[TB] FAIL flush_count: got %0d expected 1", flush_count);
    end
    checks++;
    if (stall_count !== 16'd1) begin
      errors++;
      $display("[TB] FAIL flush_stall_count: got %0d expected 1", stall_count);
    end
    drain();
  endtask

  // Reset pulse in the middle of a stall, away from any clock edge.
  task automatic test_async_reset();
    apply_stimulus(5'd1, 5'd0, 1'b1, 1'b0, 5'd2, 1'b1, 1'b1);
    tick();
    apply_stimulus(5'd0, 5'd2, 1'b0, 1'b1, 5'd4, 1'b1, 1'b0);
    #1;
    checks++;
    if (pc_write !== 1'b0 || id_ex_bubble !== 1'b1) begin
      errors++;
      $display("[TB] FAIL arst_pre_stall: got pc_write=%b bubble=%b expected 0/1",
               pc_write, id_ex_bubble);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({pc_write, if_id_write, if_id_flush, id_ex_bubble} !== 4'b1100) begin
      errors++;
      $display("[TB] FAIL arst_ctrl: got %b expected 1100",
               {pc_write, if_id_write, if_id_flush, id_ex_bubble});
    end
    checks++;
    if (stall_count !== 16'd0 || flush_count !== 16'd0) begin
      errors++;
      $display("[TB] FAIL arst_cnt: got %0d/%0d expected 0/0", stall_count, flush_count);
    end
    apply_stimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    tick();
  endtask

  // Twenty separate load-use pairs: the 16-bit counter reads 20, the 4-bit
  // one saturates at 15.
  task automatic test_saturation();
    for (int i = 0; i < 20; i++) begin
      apply_stimulus(5'd1, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1);
      tick();
      apply_stimulus(5'd7, 5'd0, 1'b1, 1'b0, 5'd8, 1'b1, 1'b0);
      tick();
    end
    checks++;
    if (stall_count !== 16'd20) begin
      errors++;
      $display("[TB] FAIL sat_wide_count: got %0d expected 20", stall_count);
    end
    checks++;
    if (sat_stall_count !== 4'd15) begin
      errors++;
      $display("[TB] FAIL sat_narrow_count: got %0d expected 15", sat_stall_count);
    end
    checks++;
    if (sat_flush_count !== 4'd0) begin
      errors++;
      $display("[TB] FAIL sat_flush_count: got %0d expected 0", sat_flush_count);
    end
    drain();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_ex_mem_forward();
    test_mem_wb_forward();
    test_priority();
    test_load_use();
    test_reg_zero();
    test_flush_vs_stall();
    test_async_reset();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_forward_unit.md
# hazard_forward_unit

Pipeline hazard controller for the 5-stage MIPS core. It shadows the destination-register information of the instructions in the ID/EX, EX/MEM and MEM/WB latches and generates the `Forward_A`/`Forward_B` select codes consumed by the Execute stage's operand muxes. It also detects load-use hazards, stalling PC and IF/ID and inserting a bubble. It applies the taken-branch flush, and keeps saturating stall/flush event counters for performance debug.

## Interface
- `REG_AW`, default 5: register-address width.
- `CNT_W`, default 16: width of event counters.

Ports:
- `clk`, in, 1: pipeline clock, rising edge.
- `reset`, in, 1: asynchronous, active-high.
- `if_id_rs`, in, REG_AW: rs field of the instruction in decode.
- `if_id_rt`, in, REG_AW: rt field of the instruction in decode.
- `dec_rs_used`, in, 1: decoded instruction reads rs.
- `dec_rt_used`, in, 1: decoded instruction reads rt (R-type, store, branch).
- `dec_dest`, in, REG_AW: decoded destination (rd or rt, already selected).
- `dec_reg_write`, in, 1: decoded instruction writes a register.
- `dec_mem_read`, in, 1: decoded instruction is a load.
- `branch_taken`, in, 1: taken branch/jump resolved in EX this cycle.
- `forward_a`, out, 2: Execute A-operand select. 00 = register file, 01 = MEM/WB write-back result, 10 = EX/MEM ALU result. 11 is never driven.
- `forward_b`, out, 2: same encoding, for the B operand.
- `pc_write`, out, 1: PC update enable.
- `if_id_write`, out, 1: IF/ID latch enable.
- `if_id_flush`, out, 1: zero the IF/ID latch at the next edge.
- `id_ex_bubble`, out, 1: load a NOP into ID/EX at the next edge.
- `stall_count`, out, CNT_W: number of load-use stall cycles, saturating.
- `flush_count`, out, CNT_W: number of branch-flush cycles, saturating.

## Operation
- Internal shadow registers mirror the pipeline latches:
  - EX slot: `rs`, `rt`, `rs_used`, `rt_used`, `dest`, `reg_write`, `mem_read`.
  - MEM slot: `dest`, `reg_write`.
  - WB slot: `dest`, `reg_write`.
- Every edge the slots advance:
  - EX ← decode inputs, or a bubble (all enables 0) when `id_ex_bubble` is high.
  - MEM ← EX.
  - WB ← MEM.
- Forwarding is combinational from the shadow registers. For `forward_a`, evaluated against the EX slot's `rs` (`forward_b` is identical with `rt`):
  - Result is 10 if MEM.reg_write, MEM.dest ≠ 0 and MEM.dest == EX.rs.
  - Otherwise 01 if WB.reg_write, WB.dest ≠ 0 and WB.dest == EX.rs.
  - Otherwise 00.
  - EX/MEM has priority over MEM/WB, so the youngest producer wins.
  - `rs_used`/`rt_used` gate the match; an unused operand always selects 00.
- Load-use hazard (combinational):
  - `lu = EX.mem_read & EX.dest≠0 & ((dec_rs_used & EX.dest==if_id_rs) | (dec_rt_used & EX.dest==if_id_rt))`.
  - When `lu` is high and `branch_taken` is low: `pc_write`=0, `if_id_write`=0, `id_ex_bubble`=1.
- Branch flush: when `branch_taken` is high, `if_id_flush`=1 and `id_ex_bubble`=1, while `pc_write`=1 and `if_id_write`=1.
  - Flush dominates a simultaneous load-use hazard: no stall, and the stall counter is not incremented.
- Idle: `pc_write`=1, `if_id_write`=1, `if_id_flush`=0, `id_ex_bubble`=0.
- Counters:
  - `stall_count` increments on every edge where the stall is asserted.
  - `flush_count` increments on every edge where `branch_taken` is high.
  - Both hold at all-ones once saturated.
- Register 0 never forwards and never causes a stall.

## Timing
- Reset is asynchronous and clears everything: all shadow slots are bubbles, the counters are 0, `forward_a`/`forward_b`=00, `pc_write`=1, `if_id_write`=1, `if_id_flush`=0, `id_ex_bubble`=0.
- Reset asserted mid-stall ends the stall immediately.
- Forward and hazard outputs have zero latency: they are valid in the same cycle, from the current register state and inputs.
- Shadow state and counters update on the rising edge of `clk`.
- Load-use costs exactly one stall cycle. On the following cycle the load is in the MEM slot and the consumer is stalled in decode. After the bubble edge, the load reaches WB when the consumer reaches EX, and forwarding resolves the dependency with 01.
- Back-to-back dependent loads produce one stall per load-use pair, never two consecutive stalls for the same pair.

## Test plan
- **EX/MEM forward:** `add $3,$1,$2` then `sub $4,$3,$5` -> in the cycle `sub` is in EX, `forward_a`=10 and `forward_b`=00.
- **MEM/WB forward and priority:**
  - `add $3` followed by an independent instruction, then `or $6,$7,$3` -> `forward_b`=01.
  - Two writers of `$3` back-to-back -> 10 (younger producer) selected.
- **Load-use:** `lw $2,0($1)` then `add $4,$2,$2` -> exactly one cycle of `pc_write`=0, `if_id_write`=0, `id_ex_bubble`=1 and `stall_count`=1. On the next cycle `add` is in EX with `forward_a`=01 and `forward_b`=01.
- **Register zero:** `addi $0,$0,5` then `add $1,$0,$0`, and `lw $0` followed by a use of `$0` -> forwards stay 00 and no stall.
- **Flush vs stall:** `branch_taken`=1 in the same cycle as a load-use match -> `if_id_flush`=1, `id_ex_bubble`=1, `pc_write`=1, `flush_count`=1 and `stall_count` unchanged.
- **Reset/saturation:**
  - Assert `reset` asynchronously mid-stall -> outputs return to their idle values without waiting for a clock edge.
  - With `CNT_W`=4, apply 20 stalls -> `stall_count` holds at 15.
